qrisc32_ex_mc: RTL
==================

Name: qrisc32_ex_mc

Overview:
- Parametrised successor of the qrisc32 execute stage.
- Single-cycle ALU, flag register and branch resolution, plus an iterative multi-cycle multiplier with valid/ready back-pressure toward decode.
- Sits between the ID and MEM stages and uses flat ports instead of pipe_struct, so DW can vary.
- Drives branch redirect (new_address) to the fetch/mem path.

Parameters:
- DW, 32: datapath width; must be ≥8 and a power of 2.
- MUL_K, 1: multiplier bits retired per cycle; must divide DW. Multiply latency is DW/MUL_K cycles.
- INC_W, 4: width of the signed post-increment field.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- pipe_stall  in  1  downstream stall; holds output registers
- in_valid  in  1  decode presents an op
- in_ready  out  1  EX accepts an op this cycle
- op  in  4  0 NOP, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 MUL, 6 SHL, 7 SHR, 8 CMP, 9 JMP, 10 JZ, 11 JNZ, 12 JC, 13 JNC, 14 SUB, 15 reserved (treated as NOP)
- ldrf  in  1  with op 10-13: conditional register load (select r1/r2), no jump
- mem_access  in  1  op is load/store; out_val_r1 becomes the address r1+r2
- val_r1  in  DW  operand 1
- val_r2  in  DW  operand 2
- incr_r2  in  INC_W  signed post-increment for r2
- incr_r2_enable  in  1  apply incr_r2
- out_valid  out  1  output registers hold a completed op
- out_val_dst  out  DW  result
- out_val_r1  out  DW  r1, or the address when mem_access=1
- out_val_r2  out  DW  r2, or r2+sext(incr_r2)
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag
- new_address_valid  out  1  one-cycle branch redirect pulse
- new_address  out  DW  branch target
- busy  out  1  multiplier iterating

Behaviour:
- Reset (async): state=IDLE; all outputs 0; flags 0; multiplier accumulator and counter 0.
- in_ready=1 only when state=IDLE and pipe_stall=0. Accept means in_valid & in_ready.
- FSM states: IDLE, MUL, DONE.
  - IDLE, accept non-MUL: result registered next edge, out_valid=1. Latency 1.
  - IDLE, accept MUL: latch operands, cnt=DW/MUL_K, go to MUL; out_valid=0, busy=1.
  - MUL: each cycle add MUL_K partial products and decrement cnt. Iteration continues even while pipe_stall=1. At cnt=1 the result is written:
    - to the outputs, and state goes to IDLE, if pipe_stall=0;
    - otherwise state goes to DONE.
  - DONE: result waits internally; writes outputs and returns to IDLE on the first cycle with pipe_stall=0.
- pipe_stall=1 freezes out_* and out_valid. Nothing is accepted.
- Accepting a NOP, or no accept while not stalled, gives out_valid=0 on the next edge.
- Arithmetic; all results are DW bits:
  - AND/OR/XOR: C=0.
  - ADD: {C,dst}=r1+r2, unsigned (DW+1)-bit sum.
  - SUB: dst=r1-r2; C=1 iff r1<r2 unsigned.
  - MUL: dst=low DW bits of the 2DW-bit unsigned product; C=1 iff the high DW bits are nonzero.
  - SHL: {C,dst}=({1'b0,r1}<<r2) as a DW+1-bit result; r2>DW gives dst=0, C=0.
  - SHR: {dst,C}=({r1,1'b0}>>r2); r2>DW gives 0,0.
  - CMP: dst=r1; Z=(r1==r2); C=(r1<r2) unsigned.
  - Z=(dst==0) for every flag-writing op except CMP.
- Flag update:
  - Ops 1-8 and 14 write flag_z/flag_c at the edge their result is written (MUL: at completion).
  - Jumps, NOP and ldrf never write flags.
- Branches (op 9-13, ldrf=0):
  - Target = r1+r2; out_val_dst=target.
  - Taken if: JMP always; JZ Z=1; JNZ Z=0; JC C=1; JNC C=0. Conditions use the flag register value at accept.
  - If taken: new_address_valid=1 for exactly one cycle at the next edge, new_address=target.
  - new_address holds its value otherwise; new_address_valid is forced 0 except on this pulse.
- ldrf=1 with op 10-13: dst = condition true ? r1 : r2; no redirect.
- Flag hazards: in_ready=0 during MUL/DONE, so a branch never sees stale flags.
- Output registers:
  - out_val_r1 = mem_access ? (r1+r2 mod 2^DW) : r1.
  - out_val_r2 = incr_r2_enable ? r2+sext(incr_r2) mod 2^DW : r2.
  - For MUL, both are the latched operand values.
- Reset asserted mid-MUL aborts the multiply immediately; no result and no flag change is visible after reset release.

Test Plan:
- ADD r1=FFFFFFFF, r2=1 -> next cycle out_val_dst=0, flag_z=1, flag_c=1, out_valid=1.
- MUL r1=00010000, r2=00010000, MUL_K=1:
  - in_ready=0 and busy=1 for 32 cycles.
  - Then dst=0, C=1, Z=1.
  - Repeat with MUL_K=4: 8 cycles.
- CMP 5,7 then JC r1=100, r2=20 -> new_address_valid pulse 1 cycle, new_address=120. JNC with the same flags -> no pulse.
- MUL completing while pipe_stall=1 for 3 cycles -> state DONE; outputs unchanged until stall drops; then result and flags appear once.
- mem_access: r1=1000, r2=24, incr_r2=-4 with enable -> out_val_r1=1024, out_val_r2=20; flags unchanged.
- Reset pulse at MUL cycle 10 -> all outputs 0 and in_ready=1 after release; flags 0.

Source files
------------

// File: rtl/qrisc32_ex_mc.sv
// ---------------------------------------------------------------------------
// qrisc32_ex_mc : parametrised execute stage of the qrisc32 pipeline.
//
// Sits between decode and memory. Provides a single-cycle ALU, the Z/C flag
// register, branch resolution with a one-cycle redirect pulse, and an
// iterative multiplier that retires MUL_K multiplier bits per cycle. While
// the multiplier is iterating (or its result is parked), in_ready stays low
// so decode is back-pressured and branches never observe stale flags.
//
// Parameters
//   DW     datapath width (>= 8, power of two)
//   MUL_K  multiplier bits retired per cycle (must divide DW)
//   INC_W  width of the signed post-increment field
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   pipe_stall          downstream stall, freezes all out_* registers
//   in_valid/in_ready   op handshake from decode
//   op, ldrf, mem_access, val_r1, val_r2, incr_r2, incr_r2_enable
//                       decoded operation and operands
//   out_valid, out_val_dst, out_val_r1, out_val_r2
//                       registered results towards memory stage
//   flag_z, flag_c      flag register
//   new_address_valid, new_address
//                       branch redirect towards fetch
//   busy                multiplier iterating
// ---------------------------------------------------------------------------
module qrisc32_ex_mc #(
    parameter int DW    = 32,
    parameter int MUL_K = 1,
    parameter int INC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             ldrf,
    input  logic             mem_access,
    input  logic [DW-1:0]    val_r1,
    input  logic [DW-1:0]    val_r2,
    input  logic [INC_W-1:0] incr_r2,
    input  logic             incr_r2_enable,
    output logic             out_valid,
    output logic [DW-1:0]    out_val_dst,
    output logic [DW-1:0]    out_val_r1,
    output logic [DW-1:0]    out_val_r2,
    output logic             flag_z,
    output logic             flag_c,
    output logic             new_address_valid,
    output logic [DW-1:0]    new_address,
    output logic             busy
);

    localparam int unsigned NITER = DW / MUL_K;
    localparam int          CW    = $clog2(NITER + 1);

    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JZ  = 4'd10;
    localparam logic [3:0] OP_JNZ = 4'd11;
    localparam logic [3:0] OP_JC  = 4'd12;
    localparam logic [3:0] OP_JNC = 4'd13;
    localparam logic [3:0] OP_SUB = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [2*DW-1:0]  mcand_q;
    logic [DW-1:0]    mplier_q;
    logic [2*DW-1:0]  acc_q;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    mr1_q;
    logic [DW-1:0]    mr2_q;

    // {carry, result} of a left shift; amounts beyond DW flush everything.
    function automatic logic [DW:0] shl_f(input logic [DW-1:0] a, input logic [DW-1:0] s);
        logic [DW:0] t;
        if (s > DW'(DW)) begin
            t = '0;
        end else begin
            t = {1'b0, a} << s;
        end
        return t;
    endfunction

    // {result, carry} of a right shift; the carry is the last bit shifted out.
    function automatic logic [DW:0] shr_f(input logic [DW-1:0] a, input logic [DW-1:0] s);
        logic [DW:0] t;
        if (s > DW'(DW)) begin
            t = '0;
        end else begin
            t = {a, 1'b0} >> s;
        end
        return t;
    endfunction

    // Handshake and status
    logic accept;
    assign in_ready = (state_q == S_IDLE) && !pipe_stall;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == S_MUL);

    // Operand side outputs
    logic signed [INC_W-1:0] incr_s;
    logic signed [DW-1:0]    incr_ext;
    logic [DW-1:0]           target_d;
    logic [DW-1:0]           r1_out_d;
    logic [DW-1:0]           r2_out_d;

    assign incr_s   = incr_r2;
    assign incr_ext = DW'(incr_s);
    assign target_d = val_r1 + val_r2;
    assign r1_out_d = mem_access ? target_d : val_r1;
    assign r2_out_d = incr_r2_enable ? (val_r2 + $unsigned(incr_ext)) : val_r2;

    // Single-cycle ALU and branch resolution
    logic [DW-1:0] alu_dst_d;
    logic          alu_c_d;
    logic          alu_z_d;
    logic          alu_wr_flags_d;
    logic          alu_valid_d;
    logic          jump_d;
    logic          cond_d;
    logic [DW:0]   wide_d;

    always_comb begin
        alu_dst_d      = '0;
        alu_c_d        = 1'b0;
        alu_wr_flags_d = 1'b1;
        alu_valid_d    = 1'b1;
        jump_d         = 1'b0;
        wide_d         = '0;
        cond_d         = 1'b0;
        case (op)
            OP_JMP: cond_d = 1'b1;
            OP_JZ:  cond_d = flag_z;
            OP_JNZ: cond_d = !flag_z;
            OP_JC:  cond_d = flag_c;
            OP_JNC: cond_d = !flag_c;
            default: cond_d = 1'b0;
        endcase
        case (op)
            OP_AND: alu_dst_d = val_r1 & val_r2;
            OP_OR:  alu_dst_d = val_r1 | val_r2;
            OP_XOR: alu_dst_d = val_r1 ^ val_r2;
            OP_ADD: begin
                wide_d    = {1'b0, val_r1} + {1'b0, val_r2};
                alu_dst_d = wide_d[DW-1:0];
                alu_c_d   = wide_d[DW];
            end
            OP_SUB: begin
                alu_dst_d = val_r1 - val_r2;
                alu_c_d   = (val_r1 < val_r2);
            end
            OP_SHL: begin
                wide_d    = shl_f(val_r1, val_r2);
                alu_dst_d = wide_d[DW-1:0];
                alu_c_d   = wide_d[DW];
            end
            OP_SHR: begin
                wide_d    = shr_f(val_r1, val_r2);
                alu_dst_d = wide_d[DW:1];
                alu_c_d   = wide_d[0];
            end
            OP_CMP: begin
                alu_dst_d = val_r1;
                alu_c_d   = (val_r1 < val_r2);
            end
            OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
                alu_wr_flags_d = 1'b0;
                // JMP ignores ldrf: only the conditional forms become selects.
                if (ldrf && (op != OP_JMP)) begin
                    alu_dst_d = cond_d ? val_r1 : val_r2;
                end else begin
                    alu_dst_d = target_d;
                    jump_d    = cond_d;
                end
            end
            OP_MUL: alu_wr_flags_d = 1'b0;
            default: begin
                alu_wr_flags_d = 1'b0;
                alu_valid_d    = 1'b0;
            end
        endcase
        alu_z_d = (op == OP_CMP) ? (val_r1 == val_r2) : (alu_dst_d == '0);
    end

    // Multiplier datapath: MUL_K shifted partial products per cycle
    logic [2*DW-1:0] mul_part_d;
    logic [2*DW-1:0] acc_sum_d;
    logic [2*DW-1:0] mul_res_d;
    logic            last_iter;
    logic            mul_commit;

    always_comb begin
        mul_part_d = '0;
        for (int k = 0; k < MUL_K; k++) begin
            if (mplier_q[k]) begin
                mul_part_d = mul_part_d + (mcand_q << k);
            end
        end
    end

    assign acc_sum_d  = acc_q + mul_part_d;
    // A parked result (DONE) already sits complete in the accumulator.
    assign mul_res_d  = (state_q == S_DONE) ? acc_q : acc_sum_d;
    assign last_iter  = (state_q == S_MUL) && (cnt_q == CW'(1));
    assign mul_commit = !pipe_stall && (last_iter || (state_q == S_DONE));

    // Registered outputs, flags and FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= S_IDLE;
            mcand_q           <= '0;
            mplier_q          <= '0;
            acc_q             <= '0;
            cnt_q             <= '0;
            mr1_q             <= '0;
            mr2_q             <= '0;
            out_valid         <= 1'b0;
            out_val_dst       <= '0;
            out_val_r1        <= '0;
            out_val_r2        <= '0;
            flag_z            <= 1'b0;
            flag_c            <= 1'b0;
            new_address_valid <= 1'b0;
            new_address       <= '0;
        end else begin
            new_address_valid <= 1'b0;

            if (mul_commit) begin
                out_valid   <= 1'b1;
                out_val_dst <= mul_res_d[DW-1:0];
                out_val_r1  <= mr1_q;
                out_val_r2  <= mr2_q;
                flag_z      <= (mul_res_d[DW-1:0] == '0);
                flag_c      <= |mul_res_d[2*DW-1:DW];
                state_q     <= S_IDLE;
            end else if (accept && (op == OP_MUL)) begin
                mcand_q   <= {{DW{1'b0}}, val_r1};
                mplier_q  <= val_r2;
                acc_q     <= '0;
                cnt_q     <= CW'(NITER);
                mr1_q     <= val_r1;
                mr2_q     <= val_r2;
                out_valid <= 1'b0;
                state_q   <= S_MUL;
            end else if (accept) begin
                out_valid   <= alu_valid_d;
                out_val_dst <= alu_dst_d;
                out_val_r1  <= r1_out_d;
                out_val_r2  <= r2_out_d;
                if (alu_wr_flags_d) begin
                    flag_z <= alu_z_d;
                    flag_c <= alu_c_d;
                end
                if (jump_d) begin
                    new_address_valid <= 1'b1;
                    new_address       <= target_d;
                end
            end else if (!pipe_stall) begin
                out_valid <= 1'b0;
            end

            // Iteration proceeds regardless of pipe_stall.
            if (state_q == S_MUL) begin
                mcand_q  <= mcand_q << MUL_K;
                mplier_q <= mplier_q >> MUL_K;
                acc_q    <= acc_sum_d;
                cnt_q    <= cnt_q - CW'(1);
                if (last_iter && pipe_stall) begin
                    state_q <= S_DONE;
                end
            end
        end
    end

endmodule
